regfile_param: RTL
==================

# regfile_param

Parametrised register file for the MIPS datapath: one synchronous write port, two asynchronous read ports, register 0 hard-wired to zero. It adds configurable word width and depth, an optional same-cycle write-to-read bypass and a sequenced bulk-clear engine with a ready handshake. It sits between the decode stage, which drives the read addresses, and writeback, which drives the write port.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 32, number of registers (power of two, ≥2)
- AW, $clog2(DEPTH), address width (derived; do not override)

- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- we  input  1  write enable
- waddr  input  AW  write address
- wdata  input  WIDTH  write data
- raddr_a  input  AW  read address, port A
- raddr_b  input  AW  read address, port B
- rdata_a  output  WIDTH  read data, port A (combinational)
- rdata_b  output  WIDTH  read data, port B (combinational)
- clr_req  input  1  request bulk clear (single-cycle pulse or level)
- ready  output  1  high when the write port accepts writes

## Operation
- Storage: DEPTH × WIDTH flops. Index 0 is never written and always reads 0.
- Write: on a rising edge with we=1, ready=1, waddr≠0, mem[waddr] ← wdata. Writes with waddr=0, or while ready=0, are discarded silently.
- Read: rdata_x = mem[raddr_x], or 0 when raddr_x=0. Both ports are independent; the same address on both ports is legal.
- Clear FSM, two states:
  - IDLE: ready=1. If clr_req=1 at the edge: go to CLEAR, set idx ← 1.
  - CLEAR: ready=0. Each edge sets mem[idx] ← 0 and idx ← idx+1. When idx=DEPTH-1 is cleared, go to IDLE. clr_req is ignored in this state.
- A clear therefore occupies DEPTH-1 cycles. ready rises on the edge that clears the last register.
- Reads during CLEAR return current contents: 0 for indices below idx, old values for indices at or above idx.
- clr_req and we both high in IDLE on the same edge: the write is performed, and the FSM enters CLEAR. That register is later cleared when idx reaches it.
- idx wraps naturally at DEPTH. It is never compared beyond DEPTH-1.

## Timing
- Reset (rst_n=0 at an edge): all mem entries ← 0, state ← IDLE, idx ← 1, ready ← 1. rdata_a/rdata_b read 0 the cycle after reset.
- Reset asserted mid-CLEAR aborts the sweep. All registers are zeroed in that one edge, and the FSM returns to IDLE.
- Write latency: data is visible on the read ports from the cycle after the write edge. With bypass enabled it is visible in the same cycle (see Configuration).
- Read latency: zero cycles (combinational from raddr and mem).
- ready is registered and changes only on clock edges.

## Configuration
- REGFILE_BYPASS_EN defined: the bypass is compiled in.
  - If we=1, ready=1, waddr≠0 and raddr_x=waddr, then rdata_x = wdata combinationally in the same cycle.
  - Applies independently to each read port.
- REGFILE_BYPASS_EN undefined: no forwarding. rdata_x shows the old contents until the edge after the write.
- The write itself, the clear FSM and the R0 rule are identical in both builds.

## Test plan
- Reset then read: hold rst_n=0 for 1 edge, release, read all addresses on A and B -> every read returns 0 and ready=1.
- Basic write/read: write 0xDEADBEEF to r5 and 0x12345678 to r31 -> next cycle raddr_a=5 gives 0xDEADBEEF and raddr_b=31 gives 0x12345678; a write of 0xFFFFFFFF to r0 -> r0 still reads 0.
- Bypass: we=1, waddr=7, wdata=0xA5A5A5A5 with raddr_a=7, r7 previously 0x1.
  - With REGFILE_BYPASS_EN: rdata_a=0xA5A5A5A5 in the same cycle.
  - Without it: rdata_a=0x1 that cycle and 0xA5A5A5A5 the next.
- Bulk clear: fill r1..r31 with index values, pulse clr_req -> ready=0 for 31 cycles; after k edges r1..rk read 0 and rk+1 still holds k+1. ready=1 after the 31st edge, and all registers read 0.
- Write during clear: issue we=1, waddr=3, wdata=0x55 while ready=0, after r3 has been cleared -> r3 still reads 0 after the clear completes.
- Reset mid-clear: assert rst_n=0 at clear cycle 10 with r20 holding 0x20 -> after one edge, all registers read 0, ready=1, and a subsequent write to r20 succeeds.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised MIPS register file.
//   One synchronous write port, two combinational read ports, R0 reads as zero,
//   and a sequenced bulk-clear engine that deasserts ready while it sweeps.
//   Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr_req,
  output logic             ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;

  // A write is accepted only while idle and never to R0.
  assign wr_en = we && ready_q && (waddr != '0);
  assign ready = ready_q;

  // Next-state: write port, clear sweep and FSM transitions.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          mem_d[waddr] = wdata;
        end
        // A write on the same edge as clr_req lands first and is swept later.
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
        end
      end
      CLEAR: begin
        mem_d[idx_q] = '0;
        idx_d        = idx_q + AW'(1);
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_d[0] = '0;
    ready_d  = (state_d == IDLE);
  end

  // State register with synchronous active-low reset zeroing all storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= AW'(1);
      ready_q <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read ports, R0 forced to zero, optional forwarding.
  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end
    if (wr_en && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end
`else
`endif
  end

endmodule
